io_out_fifo: RTL and testbench
==============================

# io_out_fifo

Output buffer between the CPU control sequencer and the external output device. Captures the data-bus byte in every cycle where the sequencer state is `STATE_MOUT_STORE` or `STATE_ROUT_STORE`, and tags it with its source. It then presents the entries first-word-fall-through to the device over a valid/ready handshake. It reports fill level and a sticky overflow flag, so software and debug logic can see dropped output.

## Interface
- DEPTH, 8, number of entries; power of two, 2..256
- WIDTH, 8, data width; matches the CPU data bus
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all storage-control state
- state  input  8  sequencer state code, encoding per `symbols.vh`; registered upstream, stable for the whole cycle
- bus_in  input  WIDTH  CPU data bus; sampled on a capture cycle
- out_ready  input  1  device accepts the head entry this cycle
- ovf_clr  input  1  synchronous clear of `overflow`
- out_data  output  WIDTH  head entry data; 0 when empty
- out_src  output  1  head entry source: 0 = MOUT (memory), 1 = ROUT (register); 0 when empty
- out_valid  output  1  head entry present (= !empty)
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  $clog2(DEPTH+1)  entries held
- overflow  output  1  sticky: a capture was dropped

## Operation
- Capture request (`wr`): `state == STATE_MOUT_STORE` or `state == STATE_ROUT_STORE`.
  - The stored tag is 1 for `STATE_ROUT_STORE` and 0 for `STATE_MOUT_STORE`.
- Pop (`rd`): `out_valid && out_ready`. `out_ready` while empty has no effect.
- Write acceptance:
  - A write is accepted when `!full`, or when `full && rd` in the same cycle (slot freed and refilled).
  - Otherwise it is dropped and `overflow` is set to 1.
- Storage: circular buffer with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits, wrapping modulo DEPTH.
  - `count` is kept as a separate register and is never derived from the pointers.
- Count update per edge:
  - accepted write only: +1
  - pop only: -1
  - both: unchanged
  - `count` never exceeds DEPTH and never underflows.
- Simultaneous write and pop when `count == 1`:
  - The old head is popped.
  - The new entry becomes head after the edge.
  - `out_valid` stays 1.
- `overflow`:
  - Set takes priority over `ovf_clr` in the same cycle.
  - Otherwise `ovf_clr` clears it.
  - It is cleared by `reset`.
- Non-capture state codes (FETCH_PC, HALT, NEXT, ...) never write. The block holds its contents while the CPU is halted and keeps draining.
- Reset values:
  - `wp = rp = count = 0`, `overflow = 0`
  - `out_valid = 0`, `empty = 1`, `full = 0`
  - `out_data = 0`, `out_src = 0`
  - Storage array contents are not reset.
- Reset asserted mid-operation discards all entries immediately and asynchronously. After release, the first capture lands at index 0.

## Timing
- Write latency: capture at rising edge N, at the end of the store cycle. `out_valid` and the head data are visible after edge N when the FIFO was empty.
- Pop completes at the edge where `out_valid && out_ready`. The next entry, or the empty indication, is visible after that edge with no bubble.
- Throughput is one write and one pop per cycle. The sequencer produces at most one store cycle per MOUT/ROUT instruction, so a burst is bounded by the instruction rate.
- `out_data`, `out_src`, `out_valid`, `full`, `empty`, `count` and `overflow` are all functions of registered state only. There are no combinational paths from `out_ready` or `bus_in`.
- `out_data` and `out_src` are held stable while `out_valid && !out_ready`.

## Test plan
- Reset, then one capture: reset pulse; one cycle `STATE_MOUT_STORE` with `bus_in = 8'hA5` -> after the edge `out_valid = 1`, `out_data = A5`, `out_src = 0`, `count = 1`; `out_ready = 1` for one cycle -> `empty = 1`, `out_data = 0`.
- Order and tag: with `out_ready = 0`, issue ROUT 11, MOUT 22, ROUT 33 -> `count = 3`; drain yields (11,1), (22,0), (33,1) in order.
- Full and overflow: with `out_ready = 0`, write 8 entries 00..07 -> `full = 1`. A ninth ROUT with 8'hFF -> `overflow = 1`, `count = 8`, FF is absent on drain. Drained sequence is 00..07. `ovf_clr` then clears `overflow`.
- Full with simultaneous pop and write: FIFO full with 00..07; write 8'h99 while `out_ready = 1` -> `count` stays 8, `overflow = 0`, drain is 01..07, 99.
- Wrap-around: 20 write/pop pairs with values 0x40+i, each pop one cycle after its write -> every value is returned in order; `count` returns to 0; pointers wrap twice with no loss.
- Reset mid-operation: 5 entries held, reset asserted asynchronously between edges -> `out_valid`, `count` and `out_data` go to 0 immediately. The next MOUT with 8'h5A drains as 5A.

Source files
------------

// File: rtl/io_out_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_out_fifo : tagged first-word-fall-through output buffer, CPU -> device |
// | Revision    : 1.0                                                          |
// +--------------------------------------------------------------------------+
module io_out_fifo #(
  parameter int         DEPTH            = 8,
  parameter int         WIDTH            = 8,
  parameter logic [7:0] STATE_MOUT_STORE = 8'h0C,
  parameter logic [7:0] STATE_ROUT_STORE = 8'h0D
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 state,
  input  logic [WIDTH-1:0]           bus_in,
  input  logic                       out_ready,
  input  logic                       ovf_clr,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_src,
  output logic                       out_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Each entry holds {source tag, data}; the tag is the MSB.
  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            wr, rd, wr_acc, tag;

  always_comb begin
    wr      = (state == STATE_MOUT_STORE) || (state == STATE_ROUT_STORE);
    tag     = (state == STATE_ROUT_STORE);
    rd      = (count_q != '0) && out_ready;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    wr_acc  = wr && ((count_q != FULL_CNT) || rd);

    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (wr_acc) wp_d = wp_q + 1'b1;
    if (rd)     rp_d = rp_q + 1'b1;

    case ({wr_acc, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wr && !wr_acc) ovf_d = 1'b1;
    else if (ovf_clr)  ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wp_q] <= {tag, bus_in};
  end

  assign out_valid = (count_q != '0);
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign out_data  = out_valid ? mem_q[rp_q][WIDTH-1:0] : '0;
  assign out_src   = out_valid ? mem_q[rp_q][WIDTH]     : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_io_out_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_io_out_fifo : scoreboard testbench for io_out_fifo                     |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_io_out_fifo;

  localparam int         DEPTH = 8;
  localparam int         WIDTH = 8;
  localparam logic [7:0] MOUT  = 8'h0C;
  localparam logic [7:0] ROUT  = 8'h0D;
  localparam logic [7:0] FETCH = 8'h01;
  localparam logic [7:0] HALT  = 8'h0F;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       state = FETCH;
  logic [WIDTH-1:0] bus_in = '0;
  logic             out_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic [3:0]       count;
  logic             overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] sb [$];
  logic       m_ovf = 1'b0;

  io_out_fifo #(
    .DEPTH(DEPTH), .WIDTH(WIDTH),
    .STATE_MOUT_STORE(MOUT), .STATE_ROUT_STORE(ROUT)
  ) dut (
    .clk(clk), .reset(reset), .state(state), .bus_in(bus_in),
    .out_ready(out_ready), .ovf_clr(ovf_clr), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    chk("count", 32'(count), 32'(sb.size()));
    chk("valid", 32'(out_valid), 32'(sb.size() > 0));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("full", 32'(full), 32'(sb.size() == DEPTH));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    if (sb.size() > 0) begin
      chk("head_data", 32'(out_data), 32'(sb[0][7:0]));
      chk("head_src", 32'(out_src), 32'(sb[0][8]));
    end else begin
      chk("idle_data", 32'(out_data), 32'h0);
      chk("idle_src", 32'(out_src), 32'h0);
    end
  endtask

  // One clock cycle: drive inputs, update the model, advance past the edge, check.
  task automatic step(input logic [7:0] st, input logic [7:0] b, input logic rdy, input logic clr);
    int  sz;
    logic pop, wr;
    state = st; bus_in = b; out_ready = rdy; ovf_clr = clr;
    sz  = sb.size();
    pop = rdy && (sz > 0);
    wr  = (st == MOUT) || (st == ROUT);
    if (pop) begin
      chk("pop_data", 32'(out_data), 32'(sb[0][7:0]));
      chk("pop_src", 32'(out_src), 32'(sb[0][8]));
      void'(sb.pop_front());
    end
    if (wr && (sz < DEPTH || pop)) sb.push_back({(st == ROUT), b});
    if (wr && !(sz < DEPTH || pop)) m_ovf = 1'b1;
    else if (clr)                   m_ovf = 1'b0;
    @(posedge clk); #1;
    chk_outputs();
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 4*DEPTH) begin
      step(FETCH, 8'h00, 1'b1, 1'b0);
      guard++;
    end
    chk("drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    step(FETCH, 8'h00, 1'b0, 1'b0);

    // Single capture
    step(MOUT, 8'hA5, 1'b0, 1'b0);
    chk("a5_data", 32'(out_data), 32'hA5);
    chk("a5_cnt", 32'(count), 32'd1);
    step(FETCH, 8'h00, 1'b1, 1'b0);
    chk("a5_empty", 32'(empty), 32'd1);

    // Order and tag, with a halt in between that must hold contents
    step(ROUT, 8'h11, 1'b0, 1'b0);
    step(MOUT, 8'h22, 1'b0, 1'b0);
    step(ROUT, 8'h33, 1'b0, 1'b0);
    chk("three", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(HALT, 8'hEE, 1'b0, 1'b0);
    drain();

    // Full and overflow
    for (int i = 0; i < 8; i++) step(MOUT, 8'(i), 1'b0, 1'b0);
    chk("full8", 32'(full), 32'd1);
    step(ROUT, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(ROUT, 8'hFE, 1'b0, 1'b1);
    chk("ovf_prio", 32'(overflow), 32'd1);
    drain();
    step(FETCH, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full with simultaneous pop and write
    for (int i = 0; i < 8; i++) step(MOUT, 8'(i), 1'b0, 1'b0);
    step(MOUT, 8'h99, 1'b1, 1'b0);
    chk("fullrw_cnt", 32'(count), 32'd8);
    chk("fullrw_ovf", 32'(overflow), 32'd0);
    drain();

    // Wrap-around with write/pop overlap at count == 1
    for (int i = 0; i < 20; i++)
      step((i % 2 == 0) ? MOUT : ROUT, 8'(8'h40 + i), (i > 0), 1'b0);
    step(FETCH, 8'h00, 1'b1, 1'b0);
    chk("wrap_cnt", 32'(count), 32'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(ROUT, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    sb.delete();
    m_ovf = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    step(MOUT, 8'h5A, 1'b0, 1'b0);
    chk("post_rst", 32'(out_data), 32'h5A);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
